// File: rtl/topo_sorter.sv
// topo_sorter: buffers the decoded edge stream, then emits every node in Kahn topological
// order, paced so the downstream read-modify-write pipeline never collides.
// Flags cycles, repeated groups, edge-buffer overflow and in-degree saturation.
module topo_sorter #(
    parameter int unsigned MAX_NODES  = 1024,
    parameter int unsigned MAX_EDGES  = 2048,
    parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES),
    parameter int unsigned EDGE_WIDTH = $clog2(MAX_EDGES),
    parameter int unsigned EMIT_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  decoding_done,
    input  logic                  edge_valid,
    input  logic                  src_node_valid,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    output logic                  sorted_valid,
    output logic [NODE_WIDTH-1:0] sorted_node,
    output logic                  sorted_done,
    output logic                  sorted_error
);
    // Scan index spans both node and edge ranges; edge counts must be able to hold MAX_EDGES.
    localparam int unsigned CW = ((EDGE_WIDTH > NODE_WIDTH) ? EDGE_WIDTH : NODE_WIDTH) + 1;
    localparam int unsigned DW = EDGE_WIDTH + 1;
    localparam int unsigned GW = $clog2(EMIT_GAP + 2);
    localparam logic [DW-1:0]         EDGE_FULL = DW'(MAX_EDGES);
    localparam logic [GW-1:0]         GAP_INIT  = GW'(EMIT_GAP);
    localparam logic [NODE_WIDTH-1:0] INDEG_MAX = '1;

    typedef enum logic [2:0] {StLoad, StClear, StIndeg, StSeed, StEmit, StDone} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  ph_q, ph_d;
    logic [DW-1:0]         edge_count_q, edge_count_d;
    logic [NODE_WIDTH:0]   num_nodes_q, num_nodes_d;
    logic [NODE_WIDTH-1:0] cur_src_q, cur_src_d;
    logic [DW-1:0]         cur_outdeg_q, cur_outdeg_d;
    logic                  group_open_q, group_open_d;
    logic [MAX_NODES-1:0]  opened_q, opened_d;
    logic [NODE_WIDTH-1:0] dst_q, dst_d;
    logic                  walking_q, walking_d;
    logic [DW-1:0]         walk_ptr_q, walk_ptr_d, walk_rem_q, walk_rem_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [NODE_WIDTH:0]   q_head_q, q_head_d, q_tail_q, q_tail_d, emitted_q, emitted_d;
    logic                  sorted_valid_q, sorted_valid_d, sorted_done_q, sorted_done_d;
    logic                  sorted_error_q, sorted_error_d;
    logic [NODE_WIDTH-1:0] sorted_node_q, sorted_node_d;

    logic [NODE_WIDTH-1:0] edge_mem   [MAX_EDGES];
    logic [DW-1:0]         first_mem  [MAX_NODES];
    logic [DW-1:0]         outdeg_mem [MAX_NODES];
    logic [NODE_WIDTH-1:0] indeg_mem  [MAX_NODES];
    logic [NODE_WIDTH-1:0] q_mem      [MAX_NODES];

    logic                  edge_we, first_we, outdeg_we, indeg_we, push_en;
    logic [EDGE_WIDTH-1:0] edge_waddr;
    logic [NODE_WIDTH-1:0] edge_wdata, first_waddr, outdeg_waddr, indeg_waddr, indeg_wdata;
    logic [NODE_WIDTH-1:0] push_node;
    logic [DW-1:0]         first_wdata, outdeg_wdata;
    logic [NODE_WIDTH-1:0] indeg_dst, indeg_idx, head_node;

    assign indeg_dst = indeg_mem[dst_q];
    assign indeg_idx = indeg_mem[idx_q[NODE_WIDTH-1:0]];
    assign head_node = q_mem[q_head_q[NODE_WIDTH-1:0]];

    // Next-state logic for the load/clear/in-degree/seed/emit sequence.
    always_comb begin
        state_d = state_q;           idx_d = idx_q;                 ph_d = ph_q;
        edge_count_d = edge_count_q; num_nodes_d = num_nodes_q;     cur_src_d = cur_src_q;
        cur_outdeg_d = cur_outdeg_q; group_open_d = group_open_q;   opened_d = opened_q;
        dst_d = dst_q;               walking_d = walking_q;         walk_ptr_d = walk_ptr_q;
        walk_rem_d = walk_rem_q;     gap_d = gap_q;                 q_head_d = q_head_q;
        q_tail_d = q_tail_q;         emitted_d = emitted_q;         sorted_valid_d = 1'b0;
        sorted_node_d = sorted_node_q; sorted_done_d = sorted_done_q;
        sorted_error_d = sorted_error_q;
        edge_we = 1'b0;  edge_waddr = '0;   edge_wdata = '0;
        first_we = 1'b0; first_waddr = '0;  first_wdata = '0;
        outdeg_we = 1'b0; outdeg_waddr = '0; outdeg_wdata = '0;
        indeg_we = 1'b0; indeg_waddr = '0;  indeg_wdata = '0;
        push_en = 1'b0;  push_node = '0;
        unique case (state_q)
            StLoad: begin
                if (src_node_valid) begin
                    if (opened_q[src_node]) sorted_error_d = 1'b1;
                    opened_d[src_node] = 1'b1;
                    first_we = 1'b1;  first_waddr = src_node;  first_wdata = edge_count_q;
                    outdeg_we = 1'b1; outdeg_waddr = src_node; outdeg_wdata = '0;
                    cur_src_d = src_node; cur_outdeg_d = '0; group_open_d = 1'b1;
                end
                if ((src_node_valid || edge_valid) && {1'b0, src_node} >= num_nodes_d)
                    num_nodes_d = {1'b0, src_node} + 1'b1;
                if (edge_valid && {1'b0, dst_node} >= num_nodes_d)
                    num_nodes_d = {1'b0, dst_node} + 1'b1;
                if (edge_valid) begin
                    // Edges with no open group or beyond buffer capacity are dropped.
                    if (!group_open_d || edge_count_q == EDGE_FULL) begin
                        sorted_error_d = 1'b1;
                    end else begin
                        edge_we = 1'b1; edge_waddr = edge_count_q[EDGE_WIDTH-1:0];
                        edge_wdata = dst_node;
                        edge_count_d = edge_count_q + 1'b1;
                        cur_outdeg_d = cur_outdeg_d + 1'b1;
                        outdeg_we = 1'b1; outdeg_waddr = cur_src_d; outdeg_wdata = cur_outdeg_d;
                    end
                end
                if (decoding_done) begin
                    state_d = StClear; idx_d = '0;
                end
            end
            StClear: begin
                if (idx_q < CW'(num_nodes_q)) begin
                    indeg_we = 1'b1; indeg_waddr = idx_q[NODE_WIDTH-1:0]; indeg_wdata = '0;
                end
                if (idx_q + 1'b1 >= CW'(num_nodes_q)) begin
                    state_d = StIndeg; idx_d = '0; ph_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIndeg: begin
                if (edge_count_q == '0) begin
                    state_d = StSeed; idx_d = '0;
                end else if (!ph_q) begin
                    dst_d = edge_mem[idx_q[EDGE_WIDTH-1:0]]; ph_d = 1'b1;
                end else begin
                    ph_d = 1'b0; indeg_we = 1'b1; indeg_waddr = dst_q;
                    if (indeg_dst == INDEG_MAX) begin
                        indeg_wdata = INDEG_MAX; sorted_error_d = 1'b1;
                    end else begin
                        indeg_wdata = indeg_dst + 1'b1;
                    end
                    if (idx_q + 1'b1 == CW'(edge_count_q)) begin
                        state_d = StSeed; idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSeed: begin
                if (idx_q < CW'(num_nodes_q) && indeg_idx == '0) begin
                    push_en = 1'b1; push_node = idx_q[NODE_WIDTH-1:0];
                end
                if (idx_q + 1'b1 >= CW'(num_nodes_q)) begin
                    state_d = StEmit; gap_d = '0; walking_d = 1'b0; ph_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StEmit: begin
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                if (walking_q) begin
                    if (!ph_q) begin
                        dst_d = edge_mem[walk_ptr_q[EDGE_WIDTH-1:0]]; ph_d = 1'b1;
                    end else begin
                        ph_d = 1'b0; indeg_we = 1'b1; indeg_waddr = dst_q;
                        indeg_wdata = indeg_dst - 1'b1;
                        if (indeg_dst == NODE_WIDTH'(1)) begin
                            push_en = 1'b1; push_node = dst_q;
                        end
                        walk_ptr_d = walk_ptr_q + 1'b1;
                        walk_rem_d = walk_rem_q - 1'b1;
                        if (walk_rem_q == DW'(1)) walking_d = 1'b0;
                    end
                end else if (q_head_q != q_tail_q) begin
                    // Pop only once the spacing window since the last pulse has elapsed.
                    if (gap_q == '0) begin
                        sorted_valid_d = 1'b1; sorted_node_d = head_node;
                        q_head_d = q_head_q + 1'b1; emitted_d = emitted_q + 1'b1;
                        gap_d = GAP_INIT; ph_d = 1'b0;
                        walk_ptr_d = first_mem[head_node];
                        walk_rem_d = opened_q[head_node] ? outdeg_mem[head_node] : '0;
                        walking_d = opened_q[head_node] && (outdeg_mem[head_node] != '0);
                    end
                end else begin
                    state_d = StDone; sorted_done_d = 1'b1;
                    if (emitted_q != num_nodes_q) sorted_error_d = 1'b1;
                end
            end
            StDone: begin
                sorted_done_d = 1'b1;
            end
            default: state_d = StLoad;
        endcase
        if (push_en) q_tail_d = q_tail_q + 1'b1;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;       idx_q <= '0;          ph_q <= 1'b0;
            edge_count_q <= '0;      num_nodes_q <= '0;    cur_src_q <= '0;
            cur_outdeg_q <= '0;      group_open_q <= 1'b0; opened_q <= '0;
            dst_q <= '0;             walking_q <= 1'b0;    walk_ptr_q <= '0;
            walk_rem_q <= '0;        gap_q <= '0;          q_head_q <= '0;
            q_tail_q <= '0;          emitted_q <= '0;      sorted_valid_q <= 1'b0;
            sorted_node_q <= '0;     sorted_done_q <= 1'b0; sorted_error_q <= 1'b0;
        end else begin
            state_q <= state_d;      idx_q <= idx_d;       ph_q <= ph_d;
            edge_count_q <= edge_count_d; num_nodes_q <= num_nodes_d; cur_src_q <= cur_src_d;
            cur_outdeg_q <= cur_outdeg_d; group_open_q <= group_open_d; opened_q <= opened_d;
            dst_q <= dst_d;          walking_q <= walking_d; walk_ptr_q <= walk_ptr_d;
            walk_rem_q <= walk_rem_d; gap_q <= gap_d;      q_head_q <= q_head_d;
            q_tail_q <= q_tail_d;    emitted_q <= emitted_d; sorted_valid_q <= sorted_valid_d;
            sorted_node_q <= sorted_node_d; sorted_done_q <= sorted_done_d;
            sorted_error_q <= sorted_error_d;
        end
    end

    // Storage arrays; CLEAR and group opens re-initialise whatever is read later.
    always_ff @(posedge clk) begin
        if (edge_we)   edge_mem[edge_waddr]     <= edge_wdata;
        if (first_we)  first_mem[first_waddr]   <= first_wdata;
        if (outdeg_we) outdeg_mem[outdeg_waddr] <= outdeg_wdata;
        if (indeg_we)  indeg_mem[indeg_waddr]   <= indeg_wdata;
        if (push_en)   q_mem[q_tail_q[NODE_WIDTH-1:0]] <= push_node;
    end

    assign sorted_valid = sorted_valid_q;
    assign sorted_node  = sorted_node_q;
    assign sorted_done  = sorted_done_q;
    assign sorted_error = sorted_error_q;
endmodule

// File: tb/tb_topo_sorter.sv
// Bench for topo_sorter: a Kahn's-algorithm reference model built from the stimulus
// predicts the emission order and error flag; a per-cycle checker compares every pulse.
module tb_topo_sorter;
    localparam int NW  = 10;
    localparam int GAP = 4;

    typedef struct {
        bit sv;
        bit ev;
        int src;
        int dst;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          decoding_done = 1'b0;
    logic          edge_valid = 1'b0;
    logic          src_node_valid = 1'b0;
    logic [NW-1:0] src_node = '0;
    logic [NW-1:0] dst_node = '0;
    logic          sorted_valid;
    logic [NW-1:0] sorted_node;
    logic          sorted_done;
    logic          sorted_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit check_en = 1'b0;
    int got = 0;
    int first_pulse = -1;
    int last_pulse = -1;
    ev_t evs[$];
    int exp_q[$];
    int model_order[$];
    int lit[$];
    bit model_err;
    int m_nn, m_ne, m_sum;

    topo_sorter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .decoding_done (decoding_done),
        .edge_valid    (edge_valid),
        .src_node_valid(src_node_valid),
        .src_node      (src_node),
        .dst_node      (dst_node),
        .sorted_valid  (sorted_valid),
        .sorted_node   (sorted_node),
        .sorted_done   (sorted_done),
        .sorted_error  (sorted_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int want);
        total++;
        if (actual != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, actual, want);
        end
    endtask

    task automatic check_le(input string name, input int actual, input int limit);
        total++;
        if (actual > limit) begin
            bad++;
            $display("FAIL %s: got %0d, want <= %0d", name, actual, limit);
        end
    endtask

    task automatic add(input bit sv, input bit ev, input int s, input int d);
        ev_t e;
        e.sv = sv; e.ev = ev; e.src = s; e.dst = d;
        evs.push_back(e);
    endtask

    // Reference: group semantics from the stream, then textbook Kahn with a FIFO.
    task automatic build_model();
        int indeg[16];
        int adj[16][16];
        int adj_n[16];
        bit opened[16];
        int q[$];
        int cur, n, d, s, t;
        model_order.delete();
        model_err = 1'b0; m_nn = 0; m_ne = 0; m_sum = 0; cur = -1;
        for (int i = 0; i < 16; i++) begin
            indeg[i] = 0; adj_n[i] = 0; opened[i] = 1'b0;
        end
        foreach (evs[i]) begin
            s = evs[i].src; t = evs[i].dst;
            if (evs[i].sv) begin
                if (opened[s]) model_err = 1'b1;
                opened[s] = 1'b1; adj_n[s] = 0; cur = s;
            end
            if ((evs[i].sv || evs[i].ev) && s + 1 > m_nn) m_nn = s + 1;
            if (evs[i].ev) begin
                if (t + 1 > m_nn) m_nn = t + 1;
                if (cur < 0) begin
                    model_err = 1'b1;
                end else begin
                    adj[cur][adj_n[cur]] = t;
                    adj_n[cur] = adj_n[cur] + 1;
                    indeg[t] = indeg[t] + 1;
                    m_ne++;
                end
            end
        end
        for (int i = 0; i < m_nn; i++) if (indeg[i] == 0) q.push_back(i);
        while (q.size() > 0) begin
            n = q.pop_front();
            model_order.push_back(n);
            for (int j = 0; j < adj_n[n]; j++) begin
                d = adj[n][j];
                indeg[d] = indeg[d] - 1;
                if (indeg[d] == 0) q.push_back(d);
            end
        end
        if (model_order.size() != m_nn) model_err = 1'b1;
        for (int i = 0; i < m_nn; i++)
            m_sum += ((2 + 2 * adj_n[i]) > (GAP + 1)) ? (2 + 2 * adj_n[i]) : (GAP + 1);
    endtask

    // Hand-computed orders pin the model itself.
    task automatic pin(input string name);
        check({name, "_model_len"}, model_order.size(), lit.size());
        foreach (lit[i])
            if (i < model_order.size()) check({name, "_model_order"}, model_order[i], lit[i]);
    endtask

    task automatic load(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk); #1;
            src_node_valid = evs[i].sv;
            edge_valid     = evs[i].ev;
            src_node       = NW'(evs[i].src);
            dst_node       = NW'(evs[i].dst);
        end
        @(posedge clk); #1;
        src_node_valid = 1'b0;
        edge_valid     = 1'b0;
    endtask

    task automatic kick();
        exp_q = model_order;
        got = 0; first_pulse = -1; last_pulse = -1; check_en = 1'b1;
        @(posedge clk); #1; decoding_done = 1'b1;
        @(posedge clk); #1; decoding_done = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int dd_cyc, waited, bound;
        bound = 2 * m_nn + 2 * m_ne + m_sum + 4;
        kick();
        dd_cyc = cyc - 1;
        waited = 1;
        while (!sorted_done && waited < bound + 8) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_done"}, int'(sorted_done), 1);
        check_le({name, "_done_latency"}, cyc - dd_cyc, bound);
        repeat (8) @(posedge clk);
        #1;
        check({name, "_error"}, int'(sorted_error), int'(model_err));
        check({name, "_pulses"}, got, model_order.size());
        check({name, "_missing"}, exp_q.size(), 0);
        if (model_order.size() > 0)
            check_le({name, "_first_latency"}, first_pulse - dd_cyc, 2 * m_nn + 2 * m_ne + 4);
        check_en = 1'b0;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Per-cycle checker: order, spacing, and no pulse together with done.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (check_en && sorted_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL order: got node %0d, want no further pulse", sorted_node);
                end else begin
                    e = exp_q.pop_front();
                    if (sorted_node != NW'(e)) begin
                        bad++;
                        $display("FAIL order: got node %0d, want %0d", sorted_node, e);
                    end
                end
                if (last_pulse >= 0) begin
                    total++;
                    if (cyc - last_pulse < GAP + 1) begin
                        bad++;
                        $display("FAIL spacing: got %0d cycles, want >= %0d",
                                 cyc - last_pulse, GAP + 1);
                    end
                end
                total++;
                if (sorted_done) begin
                    bad++;
                    $display("FAIL valid_with_done: got done=1, want 0");
                end
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
                got++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        #2 rst_n = 1'b0;
        #1;
        check("reset_valid", int'(sorted_valid), 0);
        check("reset_node", int'(sorted_node), 0);
        check("reset_done", int'(sorted_done), 0);
        check("reset_error", int'(sorted_error), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Chain 0->1->2
        evs.delete(); add(1, 1, 0, 1); add(1, 1, 1, 2);
        build_model(); lit = '{0, 1, 2}; pin("chain");
        check("chain_model_err", int'(model_err), 0);
        load(0, evs.size());
        finish_run("chain");

        // Diamond 0->{1,2}, 1->3, 2->3
        do_reset();
        evs.delete(); add(1, 1, 0, 1); add(0, 1, 0, 2); add(1, 1, 1, 3); add(1, 1, 2, 3);
        build_model(); lit = '{0, 1, 2, 3}; pin("diamond");
        load(0, evs.size());
        finish_run("diamond");

        // Cycle 0<->1 plus isolated 2
        do_reset();
        evs.delete(); add(1, 1, 0, 1); add(1, 1, 1, 0); add(1, 0, 2, 0);
        build_model(); lit = '{2}; pin("cycle");
        check("cycle_model_err", int'(model_err), 1);
        load(0, evs.size());
        finish_run("cycle");

        // Pacing: groups 0..4, one edge 4->0
        do_reset();
        evs.delete();
        for (int i = 0; i < 4; i++) add(1, 0, i, 0);
        add(1, 1, 4, 0);
        build_model(); lit = '{1, 2, 3, 4, 0}; pin("pacing");
        load(0, evs.size());
        finish_run("pacing");

        // Repeated group for source 0
        do_reset();
        evs.delete(); add(1, 1, 0, 1); add(1, 1, 2, 3); add(1, 1, 0, 4);
        build_model(); lit = '{0, 2, 4, 3}; pin("repeat");
        load(0, 2);
        check("repeat_err_before", int'(sorted_error), 0);
        load(2, 3);
        check("repeat_err_after", int'(sorted_error), 1);
        finish_run("repeat");

        // Reset mid-EMIT of the chain, then the diamond
        do_reset();
        evs.delete(); add(1, 1, 0, 1); add(1, 1, 1, 2);
        build_model();
        load(0, evs.size());
        kick();
        waited = 0;
        while (got == 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("midemit_first_pulse", got, 1);
        #2;
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midemit_valid", int'(sorted_valid), 0);
        check("midemit_node", int'(sorted_node), 0);
        check("midemit_done", int'(sorted_done), 0);
        check("midemit_error", int'(sorted_error), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        evs.delete(); add(1, 1, 0, 1); add(0, 1, 0, 2); add(1, 1, 1, 3); add(1, 1, 2, 3);
        build_model(); lit = '{0, 1, 2, 3}; pin("reload");
        load(0, evs.size());
        finish_run("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
